// File: rtl/vram_scan_arbiter_if.sv
// ============================================================================
// Module   : vram_scan_arbiter_if
// Brief    : Framebuffer RAM port bundle between the scan arbiter and the RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vram_scan_arbiter_if;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_wmask;
    logic [15:0] mem_rdata;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/vram_scan_arbiter.sv
// ============================================================================
// Module   : vram_scan_arbiter
// Brief    : Shares the 1bpp framebuffer RAM between VGA scanout (priority) and
//            plotter pixel writes; emits the aligned pixel bit and syncs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_scan_arbiter (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  x_i,
    input  logic [9:0]                  y_i,
    input  logic                        blank_i,
    input  logic                        hsync_i,
    input  logic                        vsync_i,
    input  logic                        plot_req_i,
    input  logic [9:0]                  plot_x_i,
    input  logic [9:0]                  plot_y_i,
    input  logic                        plot_value_i,
    output logic                        plot_ack_o,
    output logic                        pixel_o,
    output logic                        hsync_o,
    output logic                        vsync_o,
    vram_scan_arbiter_if.master         mem
);

    localparam logic [9:0] c_H_ACTIVE   = 10'd640;
    localparam logic [9:0] c_V_ACTIVE   = 10'd480;
    localparam logic [9:0] c_LAST_LOAD  = 10'd624;
    localparam logic [9:0] c_V_ARM_ROW  = 10'd524;
    localparam logic [9:0] c_V_LAST_PF  = 10'd479;

    logic [9:0]  last_x_q;
    logic [15:0] cur_q,        cur_d;
    logic [15:0] nxt_q,        nxt_d;
    logic [14:0] fetch_addr_q, fetch_addr_d;
    logic        scan_pend_q,  scan_pend_d;
    logic        armed_q,      armed_d;
    logic        rd_pend_q;
    logic        pixel_q,      pixel_d;
    logic        hsync_q;
    logic        vsync_q;

    logic        w_pix_start;
    logic        w_line_pf;
    logic        w_word_load;
    logic [9:0]  w_y_next;
    logic [14:0] w_next_row_base;
    logic [14:0] w_plot_row_base;
    logic [14:0] w_plot_addr;
    logic        w_plot_in_range;

    assign w_pix_start = (x_i != last_x_q);
    assign w_line_pf   = w_pix_start && (x_i == c_H_ACTIVE);
    assign w_word_load = w_pix_start && !blank_i && (x_i[3:0] == 4'd0);

    // row*40 as (row<<5)+(row<<3)
    assign w_y_next        = y_i + 10'd1;
    assign w_next_row_base = {w_y_next, 5'b0} + {2'b0, w_y_next, 3'b0};
    assign w_plot_row_base = {plot_y_i, 5'b0} + {2'b0, plot_y_i, 3'b0};
    assign w_plot_addr     = w_plot_row_base + {9'd0, plot_x_i[9:4]};
    assign w_plot_in_range = (plot_x_i < c_H_ACTIVE) && (plot_y_i < c_V_ACTIVE);

    // Scan reads win outright; plot grant is masked during reset so the
    // combinational outputs sit at their idle values without a clock edge.
    always_comb begin
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 15'd0;
        mem.mem_wdata = {16{plot_value_i}};
        mem.mem_wmask = 16'd1 << plot_x_i[3:0];
        plot_ack_o    = 1'b0;
        if (scan_pend_q) begin
            mem.mem_re   = 1'b1;
            mem.mem_addr = fetch_addr_q;
        end else if (plot_req_i && !rst) begin
            plot_ack_o = 1'b1;
            if (w_plot_in_range) begin
                mem.mem_we   = 1'b1;
                mem.mem_addr = w_plot_addr;
            end
        end
    end

    always_comb begin
        cur_d        = cur_q;
        nxt_d        = rd_pend_q ? mem.mem_rdata : nxt_q;
        fetch_addr_d = fetch_addr_q;
        scan_pend_d  = scan_pend_q;
        armed_d      = armed_q;

        if (scan_pend_q) begin
            scan_pend_d  = 1'b0;
            fetch_addr_d = fetch_addr_q + 15'd1;
        end

        if (w_line_pf) begin
            if (y_i == c_V_ARM_ROW) begin
                fetch_addr_d = 15'd0;
                scan_pend_d  = 1'b1;
                armed_d      = 1'b1;
            end else if (y_i < c_V_LAST_PF) begin
                fetch_addr_d = w_next_row_base;
                scan_pend_d  = 1'b1;
            end
        end

        if (w_word_load) begin
            cur_d = nxt_q;
            if (x_i < c_LAST_LOAD) begin
                scan_pend_d = 1'b1;
            end
        end

        // On the load cycle cur still holds the previous word, so bit 0 comes from nxt.
        if (blank_i || !armed_q) begin
            pixel_d = 1'b0;
        end else if (w_word_load) begin
            pixel_d = nxt_q[0];
        end else begin
            pixel_d = cur_q[x_i[3:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_x_q     <= 10'd0;
            cur_q        <= 16'd0;
            nxt_q        <= 16'd0;
            fetch_addr_q <= 15'd0;
            scan_pend_q  <= 1'b0;
            armed_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            pixel_q      <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
        end else begin
            last_x_q     <= x_i;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            fetch_addr_q <= fetch_addr_d;
            scan_pend_q  <= scan_pend_d;
            armed_q      <= armed_d;
            rd_pend_q    <= scan_pend_q;
            pixel_q      <= pixel_d;
            hsync_q      <= hsync_i;
            vsync_q      <= vsync_i;
        end
    end

    assign pixel_o = pixel_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;

endmodule

`default_nettype wire
